// File: rtl/sr_readback.sv
`default_nettype none
// ============================================================================
// Module      : sr_readback
// Description : Serial readback of the chip configuration shift register into
//               a parallel word, with comparison against an expected word.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_readback #(
  parameter int DATA_WIDTH = 170,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  dout_sr,
  input  logic [DATA_WIDTH-1:0] expect_word,
  output logic                  cap_sr,
  output logic                  clk_sr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid,
  output logic                  match,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CAPTURE  = 3'd1,
    S_SETTLE   = 3'd2,
    S_SHIFT_LO = 3'd3,
    S_SHIFT_HI = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [CNT_WIDTH-1:0] c_last_bit = CNT_WIDTH'(DATA_WIDTH - 1);

  state_t                  r_state;
  logic [CNT_WIDTH-1:0]    r_count;
  logic [DATA_WIDTH-1:0]   r_shift;
  logic [DATA_WIDTH-1:0]   r_dout;
  logic                    r_cap;
  logic                    r_clk_sr;
  logic                    r_valid;
  logic                    r_match;
  logic                    r_busy;

  // Strobes are computed for the state being entered so they are registered
  // alongside the state and never glitch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_shift  <= '0;
      r_dout   <= '0;
      r_cap    <= 1'b0;
      r_clk_sr <= 1'b0;
      r_valid  <= 1'b0;
      r_match  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_CAPTURE;
            r_cap   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_CAPTURE: begin
          r_state <= S_SETTLE;
          r_cap   <= 1'b0;
        end
        S_SETTLE: begin
          r_state  <= S_SHIFT_LO;
          r_count  <= '0;
          r_clk_sr <= 1'b0;
        end
        S_SHIFT_LO: begin
          for (int i = 0; i < DATA_WIDTH; i++) begin
            if (r_count == CNT_WIDTH'(i)) r_shift[i] <= dout_sr;
          end
          r_state  <= S_SHIFT_HI;
          r_clk_sr <= 1'b1;
        end
        S_SHIFT_HI: begin
          r_count  <= r_count + 1'b1;
          r_clk_sr <= 1'b0;
          if (r_count == c_last_bit) begin
            // The last bit landed on the previous edge, so the word is complete.
            r_state <= S_DONE;
            r_valid <= 1'b1;
            r_dout  <= r_shift;
            r_match <= (r_shift == expect_word);
          end else begin
            r_state <= S_SHIFT_LO;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          r_cap    <= 1'b0;
          r_clk_sr <= 1'b0;
          r_valid  <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign cap_sr = r_cap;
  assign clk_sr = r_clk_sr;
  assign dout   = r_dout;
  assign valid  = r_valid;
  assign match  = r_match;
  assign busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sr_readback.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_readback
// Description : Directed bench for sr_readback against circular chip SR models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_readback;

  localparam int WA = 8;
  localparam int WB = 170;
  localparam int NC = 24;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start_a = 1'b0;
  logic           start_b = 1'b0;
  logic [WA-1:0]  chip_a = '0;
  logic [WB-1:0]  chip_b = '0;
  logic [WA-1:0]  exp_a = '0;
  logic [WB-1:0]  exp_b = '0;
  logic           dout_sr_a, dout_sr_b;
  logic           cap_sr_a, clk_sr_a, valid_a, match_a, busy_a;
  logic           cap_sr_b, clk_sr_b, valid_b, match_b, busy_b;
  logic [WA-1:0]  dout_a;
  logic [WB-1:0]  dout_b;
  logic           prev_a = 1'b0;
  logic           prev_b = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [31:0]    cap_m, clk_m, busy_m, valid_m;
  logic [WA-1:0]  dout_v, dout_rst;
  logic           match_v, got_valid;
  logic [4:0]     outs_rst;

  assign dout_sr_a = chip_a[0];
  assign dout_sr_b = chip_b[0];

  always #5 clk = ~clk;

  sr_readback #(.DATA_WIDTH(WA), .CNT_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .dout_sr(dout_sr_a),
    .expect_word(exp_a), .cap_sr(cap_sr_a), .clk_sr(clk_sr_a),
    .dout(dout_a), .valid(valid_a), .match(match_a), .busy(busy_a)
  );

  sr_readback #(.DATA_WIDTH(WB), .CNT_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .dout_sr(dout_sr_b),
    .expect_word(exp_b), .cap_sr(cap_sr_b), .clk_sr(clk_sr_b),
    .dout(dout_b), .valid(valid_b), .match(match_b), .busy(busy_b)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clk; the chips shift on each observed clk_sr rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (clk_sr_a && !prev_a) chip_a = {chip_a[0], chip_a[WA-1:1]};
    if (clk_sr_b && !prev_b) chip_b = {chip_b[0], chip_b[WB-1:1]};
    prev_a = clk_sr_a;
    prev_b = clk_sr_b;
  endtask

  // Sample c is the cycle entered by edge c-1; start_mask[c] is seen at edge c.
  task automatic run_a(input logic [WA-1:0] chip_init, input logic [31:0] start_mask,
                       input int rst_at);
    chip_a    = chip_init;
    cap_m     = '0;
    clk_m     = '0;
    busy_m    = '0;
    valid_m   = '0;
    got_valid = 1'b0;
    dout_v    = '0;
    match_v   = 1'b0;
    dout_rst  = '1;
    outs_rst  = '1;
    start_a   = 1'b1;
    for (int c = 1; c <= NC; c++) begin
      tick();
      cap_m[c]   = cap_sr_a;
      clk_m[c]   = clk_sr_a;
      busy_m[c]  = busy_a;
      valid_m[c] = valid_a;
      if (valid_a && !got_valid) begin
        got_valid = 1'b1;
        dout_v    = dout_a;
        match_v   = match_a;
      end
      if (c == rst_at + 1) begin
        dout_rst = dout_a;
        outs_rst = {cap_sr_a, clk_sr_a, valid_a, match_a, busy_a};
      end
      start_a = start_mask[c];
      rst     = (c == rst_at) ? 1'b0 : 1'b1;
    end
    start_a = 1'b0;
    rst     = 1'b1;
  endtask

  task automatic run_b(input logic [WB-1:0] expw, input logic exp_match, input logic [WB-1:0] pattern);
    int cyc;
    int pulses;
    exp_b   = expw;
    chip_b  = pattern;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    cyc     = 1;
    pulses  = 0;
    while (!valid_b && cyc < 400) begin
      tick();
      cyc++;
      if (clk_sr_b && !cap_sr_b && busy_b) pulses += 0;
      if (clk_sr_b) pulses++;
    end
    check("b_valid_cycle", 256'(cyc), 256'(2 * WB + 3));
    check("b_clk_pulses", 256'(pulses), 256'(WB));
    check("b_dout", 256'(dout_b), 256'(pattern));
    check("b_match", 256'(match_b), 256'(exp_match));
    check("b_chip_restored", 256'(chip_b), 256'(pattern));
    tick();
    check("b_idle_after", 256'({busy_b, valid_b}), 256'(0));
  endtask

  typedef struct {
    logic [WA-1:0] chip;
    logic [WA-1:0] expw;
    logic          exp_match;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] e_cap, e_clk, e_busy, e_valid;
  logic [WB-1:0] pat_b, dout_b_first;
  int          wait_c;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'hA5, 8'hA5, 1'b1};
    vecs[1] = '{8'hA5, 8'h5A, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b1};
    vecs[3] = '{8'hFF, 8'hFE, 1'b0};
    vecs[4] = '{8'h81, 8'h81, 1'b1};
    vecs[5] = '{8'h3C, 8'hC3, 1'b0};

    // Expected waveforms for one normal 8-bit transaction.
    e_cap   = 32'd1 << 1;
    e_valid = 32'd1 << (2 * WA + 3);
    e_clk   = '0;
    e_busy  = '0;
    for (int k = 0; k < WA; k++) e_clk[4 + 2 * k] = 1'b1;
    for (int c = 1; c <= 2 * WA + 3; c++) e_busy[c] = 1'b1;

    rst = 1'b0;
    repeat (3) tick();
    check("reset_outs_a", 256'({cap_sr_a, clk_sr_a, valid_a, match_a, busy_a}), 256'(0));
    check("reset_dout_a", 256'(dout_a), 256'(0));
    check("reset_outs_b", 256'({cap_sr_b, clk_sr_b, valid_b, match_b, busy_b}), 256'(0));
    check("reset_dout_b", 256'(dout_b), 256'(0));
    rst = 1'b1;
    tick();

    foreach (vecs[i]) begin
      exp_a = vecs[i].expw;
      run_a(vecs[i].chip, 32'd0, -10);
      check($sformatf("v%0d_cap", i), 256'(cap_m), 256'(e_cap));
      check($sformatf("v%0d_clk_sr", i), 256'(clk_m), 256'(e_clk));
      check($sformatf("v%0d_busy", i), 256'(busy_m), 256'(e_busy));
      check($sformatf("v%0d_valid", i), 256'(valid_m), 256'(e_valid));
      check($sformatf("v%0d_dout", i), 256'(dout_v), 256'(vecs[i].chip));
      check($sformatf("v%0d_match", i), 256'(match_v), 256'(vecs[i].exp_match));
      check($sformatf("v%0d_chip_restored", i), 256'(chip_a), 256'(vecs[i].chip));
      check($sformatf("v%0d_dout_held", i), 256'(dout_a), 256'(vecs[i].chip));
    end

    // Extra start pulses during a transaction are ignored.
    exp_a = 8'h5A;
    run_a(8'h5A, (32'd1 << 5) | (32'd1 << 12), -10);
    check("ign_cap", 256'(cap_m), 256'(e_cap));
    check("ign_clk_sr", 256'(clk_m), 256'(e_clk));
    check("ign_valid", 256'(valid_m), 256'(e_valid));
    check("ign_dout", 256'(dout_v), 256'(8'h5A));
    check("ign_match", 256'(match_v), 256'(1));

    // Reset seen at edge 9, mid-shift.
    run_a(8'hC6, 32'd0, 9);
    check("rst_outs", 256'(outs_rst), 256'(0));
    check("rst_dout", 256'(dout_rst), 256'(0));
    check("rst_valid", 256'(valid_m), 256'(0));
    check("rst_cap", 256'(cap_m), 256'(e_cap));
    check("rst_clk_sr", 256'(clk_m), 256'((32'd1 << 4) | (32'd1 << 6) | (32'd1 << 8)));
    check("rst_busy", 256'(busy_m), 256'(32'h0000_03FE));
    exp_a = 8'h3C;
    run_a(8'h3C, 32'd0, -10);
    check("post_rst_valid", 256'(valid_m), 256'(e_valid));
    check("post_rst_dout", 256'(dout_v), 256'(8'h3C));
    check("post_rst_match", 256'(match_v), 256'(1));

    // start held continuously: next CAPTURE at cycle 21.
    exp_a = 8'h96;
    run_a(8'h96, 32'hFFFF_FFFE, -10);
    check("b2b_cap", 256'(cap_m), 256'(e_cap | (32'd1 << 21)));
    check("b2b_clk_sr", 256'(clk_m), 256'(e_clk | (32'd1 << 24)));
    check("b2b_busy", 256'(busy_m), 256'(e_busy | 32'h01E0_0000));
    check("b2b_valid", 256'(valid_m), 256'(e_valid));
    check("b2b_dout", 256'(dout_v), 256'(8'h96));
    wait_c = 0;
    while (busy_a && wait_c < 60) begin
      tick();
      wait_c++;
    end
    check("b2b_second_done", 256'(busy_a), 256'(0));
    check("b2b_second_dout", 256'(dout_a), 256'(8'h96));

    // Full-width readback with alternating pattern.
    pat_b = {(WB / 2){2'b10}};
    run_b(pat_b, 1'b1, pat_b);
    dout_b_first = dout_b;
    run_b(pat_b ^ (170'd1 << 169), 1'b0, pat_b);
    check("b_dout_unchanged", 256'(dout_b), 256'(dout_b_first));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sr_readback.md
Name: sr_readback

Overview:
- Reads the configuration shift register back out of the chip, serially, and assembles a parallel word.
- Drives the chip's capture strobe and shift clock, samples the serial output dout_sr, and presents the word on dout.
- Compares dout against an expected word, normally the word just written, and flags a match.
- Sits beside the SR write controller in the shift-register read/write path. Fabric logic uses it to verify configuration after every write.

Parameters:
- DATA_WIDTH, 170, number of bits read back. Equals the chip shift-register length.
- CNT_WIDTH, 8, bit-counter width. Must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- clk  in  1  system clock. All logic is on the rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  single-cycle request to begin a readback. Sampled only in IDLE.
- dout_sr  in  1  serial data from the chip shift-register output.
- expect_word  in  DATA_WIDTH  reference word for comparison. Sampled when DONE is entered.
- cap_sr  out  1  chip capture/parallel-load strobe, one clk cycle wide.
- clk_sr  out  1  chip shift clock. Registered, glitch-free, at clk/2 during shifting.
- dout  out  DATA_WIDTH  assembled readback word. Holds its value until the next DONE or reset.
- valid  out  1  one-cycle pulse: dout and match are updated.
- match  out  1  1 when dout == expect_word. Updated together with dout.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset, applied when rst==0 at a clk edge:
  - State goes to IDLE.
  - cap_sr, clk_sr, valid, busy, match = 0; dout = 0; bit counter = 0; internal shift register = 0.
  - Reset overrides start and any operation in progress. A transaction aborted by reset produces no valid.
- Outputs are Moore outputs, registered with the state. Every value below is the value during the cycle the FSM is in that state.
- States:
  - IDLE: all strobes 0, busy=0. start=1 -> CAPTURE; otherwise stay.
  - CAPTURE: cap_sr=1, busy=1. Unconditionally -> SETTLE.
  - SETTLE: cap_sr=0; one cycle for the chip output to become valid. Clear counter -> SHIFT_LO.
  - SHIFT_LO: clk_sr=0.
    - At the closing edge, sample dout_sr into internal bit position [count].
    - Bit 0 is the first bit out, i.e. LSB-first, the same order the write controller uses.
    - -> SHIFT_HI.
  - SHIFT_HI: clk_sr=1; the chip shifts on the clk_sr rising edge.
    - At the closing edge, count <= count+1.
    - If count == DATA_WIDTH-1 -> DONE; else -> SHIFT_LO.
  - DONE:
    - valid=1, busy=1.
    - dout = internal register.
    - match = (internal register == expect_word), with expect_word sampled on the edge that enters DONE.
    - Unconditionally -> IDLE.
- Exactly DATA_WIDTH clk_sr rising edges occur per transaction. A circular chip register therefore returns to its original contents.
- Timing, with start seen at edge 0:
  - CAPTURE is cycle 1; SETTLE is cycle 2.
  - Bit k: SHIFT_LO at cycle 3+2k, SHIFT_HI at cycle 4+2k.
  - DONE at cycle 2*DATA_WIDTH+3; IDLE at the following cycle.
- start while busy is ignored and not queued.
- start in the same cycle that DONE exits is ignored. A new start is accepted from the first IDLE cycle.
- dout is never partially updated. Bits become visible only in DONE.
- Counter increments only in SHIFT_HI and never wraps within a transaction.

Test Plan:
1. DATA_WIDTH=8; bench models an 8-bit circular chip SR preloaded with 0xA5; pulse start -> exactly 1 cap_sr pulse, 8 clk_sr pulses; valid at cycle 19; dout=0xA5; busy high for cycles 1..19.
2. Default DATA_WIDTH=170; chip SR loaded with alternating 1010...; expect_word equal -> match=1. Repeat with expect_word bit 169 flipped -> match=0; dout unchanged between the two runs.
3. Pulse start again at cycles 5 and 12 during a transaction -> ignored; single valid; 8 clk_sr pulses.
4. rst=0 at cycle 9 mid-shift -> next cycle all outputs 0, dout=0, no valid. A fresh start after release -> normal transaction.
5. Back-to-back: start held high continuously -> new CAPTURE begins the cycle after the first IDLE. No clk_sr or cap_sr overlap between transactions.
6. Check clk_sr for glitches and period: high and low each exactly 1 clk cycle while shifting; 0 in IDLE, CAPTURE, SETTLE and DONE.
